// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 key tracker: frame/decoder state encodings,
// scan-code prefix bytes, the event record and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        E0   = 2'd1,
        F0   = 2'd2,
        E0F0 = 2'd3
    } dec_state_t;

    localparam logic [7:0] PS2_EXT_BYTE = 8'hE0;
    localparam logic [7:0] PS2_BRK_BYTE = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_event_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronisers, PS2_CLK glitch filter, frame FSM and
// idle timeout. Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
    logic          clk_filt_r;
    logic [FW-1:0] flt_cnt_r;
    logic [TW-1:0] tmo_cnt_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic [7:0]    byte_r;
    logic          byte_valid_r, frame_err_r;
    rx_state_t     state_r, state_n;
    logic          fall_s, timeout_s, parity_ok_s, strobe_s, err_s;

`ifdef PS2_PARITY_CHECK_EN
    logic par_r;
    assign parity_ok_s = odd_parity_ok(shift_r, par_r);
`else
    assign parity_ok_s = 1'b1;
`endif

    // Two-flop synchronisers; both lines idle high
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= PS2_CLK;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= PS2_DAT;
            dat_sync_r <= dat_meta_r;
        end
    end

    // PS2_CLK only changes after FILTER_LEN consecutive samples disagree with it
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            clk_filt_r <= 1'b1;
            flt_cnt_r  <= FW'(0);
        end else if (clk_sync_r == clk_filt_r) begin
            flt_cnt_r <= FW'(0);
        end else if (flt_cnt_r == FLT_LAST) begin
            clk_filt_r <= clk_sync_r;
            flt_cnt_r  <= FW'(0);
        end else begin
            flt_cnt_r <= flt_cnt_r + FW'(1);
        end
    end

    assign fall_s    = (clk_sync_r != clk_filt_r) && (flt_cnt_r == FLT_LAST) && clk_filt_r;
    assign timeout_s = (state_r != IDLE) && !fall_s && (tmo_cnt_r == TMO_LAST);

    // Frame state register
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Frame next-state logic; a stalled line aborts from any non-idle state
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s && !dat_sync_r) state_n = DATA;
                else                       state_n = IDLE;
            end
            DATA: begin
                if (timeout_s)                        state_n = IDLE;
                else if (fall_s && bit_cnt_r == 3'd7) state_n = PARITY;
                else                                  state_n = DATA;
            end
            PARITY: begin
                if (timeout_s)   state_n = IDLE;
                else if (fall_s) state_n = STOP;
                else             state_n = PARITY;
            end
            STOP: begin
                if (timeout_s || fall_s) state_n = IDLE;
                else                     state_n = STOP;
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame outputs: byte strobe on a good stop bit, error on bad stop/parity/timeout
    always_comb begin
        strobe_s = 1'b0;
        err_s    = 1'b0;
        if (state_r == STOP && fall_s) begin
            if (!dat_sync_r || !parity_ok_s) err_s = 1'b1;
            else                             strobe_s = 1'b1;
        end else if (timeout_s) begin
            err_s = 1'b1;
        end else begin
            strobe_s = 1'b0;
        end
    end

    // Bit shifting, bit count and idle timer
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            tmo_cnt_r <= TW'(0);
`ifdef PS2_PARITY_CHECK_EN
            par_r     <= 1'b0;
`endif
        end else begin
            tmo_cnt_r <= (state_r == IDLE || fall_s) ? TW'(0) : tmo_cnt_r + TW'(1);
            if (state_r == IDLE) begin
                bit_cnt_r <= 3'd0;
            end else if (state_r == DATA && fall_s) begin
                shift_r   <= {dat_sync_r, shift_r[7:1]};
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
`ifdef PS2_PARITY_CHECK_EN
            if (state_r == PARITY && fall_s) par_r <= dat_sync_r;
`endif
        end
    end

    // Registered byte/strobe/error outputs
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= strobe_s;
            frame_err_r  <= err_s;
            if (strobe_s) byte_r <= shift_r;
        end
    end

    assign rx_byte  = byte_r;
    assign rx_valid = byte_valid_r;
    assign rx_err   = frame_err_r;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder with per-key held state and an event FIFO.
// PS2_PARITY_CHECK_EN (passed through to ps2_rx_frame) enables parity rejection.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int                      NUM_KEYS    = 5,
    parameter logic [9*NUM_KEYS-1:0]   KEY_CODES   = {9'h02D, 9'h029, 9'h021, 9'h01B, 9'h01D},
    parameter int                      FIFO_DEPTH  = 4,
    parameter int                      FILTER_LEN  = 8,
    parameter int                      TIMEOUT_CYC = 50000
) (
    input  logic                clock50,
    input  logic                reset,
    input  logic                PS2_CLK,
    input  logic                PS2_DAT,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [7:0]          ev_code,
    output logic                ev_ext,
    output logic                ev_break,
    output logic                frame_err,
    output logic                ev_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [7:0]          rx_byte_s;
    logic                rx_valid_s, rx_err_s;
    dec_state_t          dec_r, dec_n;
    ps2_event_t          ev_s, head_r, head_n;
    logic                push_s, pop_s, full_s, wr_en_s, ovf_s, valid_n;
    logic [AW:0]         wr_r, rd_r, wr_n, rd_n;
    ps2_event_t          mem_r [FIFO_DEPTH];
    logic [NUM_KEYS-1:0] key_down_r, key_down_n;
    logic                ev_valid_r, ev_overflow_r;

    ps2_rx_frame #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clock50  (clock50),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .rx_byte  (rx_byte_s),
        .rx_valid (rx_valid_s),
        .rx_err   (rx_err_s)
    );

    // Decoder state register
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            dec_r <= NORM;
        end else begin
            dec_r <= dec_n;
        end
    end

    // Prefix bytes accumulate ext/break flags; any other byte closes the event
    always_comb begin
        dec_n = dec_r;
        if (!rx_valid_s) begin
            dec_n = dec_r;
        end else if (rx_byte_s == PS2_EXT_BYTE) begin
            case (dec_r)
                F0, E0F0: dec_n = E0F0;
                default:  dec_n = E0;
            endcase
        end else if (rx_byte_s == PS2_BRK_BYTE) begin
            case (dec_r)
                E0, E0F0: dec_n = E0F0;
                default:  dec_n = F0;
            endcase
        end else begin
            dec_n = NORM;
        end
    end

    // Decoder outputs: event record and push strobe
    always_comb begin
        ev_s.code = rx_byte_s;
        ev_s.ext  = (dec_r == E0) || (dec_r == E0F0);
        ev_s.brk  = (dec_r == F0) || (dec_r == E0F0);
        push_s    = rx_valid_s && (rx_byte_s != PS2_EXT_BYTE) && (rx_byte_s != PS2_BRK_BYTE);
    end

    // Held-key map follows every completed event, even one the FIFO drops
    always_comb begin
        key_down_n = key_down_r;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (push_s && ({ev_s.ext, ev_s.code} == KEY_CODES[i*9 +: 9])) key_down_n[i] = ~ev_s.brk;
            else                                                         key_down_n[i] = key_down_r[i];
        end
    end

    // FIFO control; head is pre-computed so the outputs come straight from flops
    always_comb begin
        pop_s   = ev_valid_r && ev_ready;
        full_s  = (wr_r[AW] != rd_r[AW]) && (wr_r[AW-1:0] == rd_r[AW-1:0]);
        wr_en_s = push_s && (!full_s || pop_s);
        ovf_s   = push_s && full_s && !pop_s;
        wr_n    = wr_en_s ? wr_r + PTR_ONE : wr_r;
        rd_n    = pop_s   ? rd_r + PTR_ONE : rd_r;
        valid_n = (wr_n != rd_n);
        if (!valid_n)                                          head_n = head_r;
        else if (wr_en_s && (wr_r[AW-1:0] == rd_n[AW-1:0]))    head_n = ev_s;
        else                                                   head_n = mem_r[rd_n[AW-1:0]];
    end

    // Event storage; contents are only observed through the pointers
    always_ff @(posedge clock50) begin
        if (wr_en_s) mem_r[wr_r[AW-1:0]] <= ev_s;
    end

    // Pointers and registered outputs
    always_ff @(posedge clock50 or posedge reset) begin
        if (reset) begin
            wr_r          <= (AW + 1)'(0);
            rd_r          <= (AW + 1)'(0);
            head_r        <= '{code: 8'h00, ext: 1'b0, brk: 1'b0};
            ev_valid_r    <= 1'b0;
            ev_overflow_r <= 1'b0;
            key_down_r    <= NUM_KEYS'(0);
        end else begin
            wr_r          <= wr_n;
            rd_r          <= rd_n;
            head_r        <= head_n;
            ev_valid_r    <= valid_n;
            ev_overflow_r <= ovf_s;
            key_down_r    <= key_down_n;
        end
    end

    assign key_down    = key_down_r;
    assign ev_valid    = ev_valid_r;
    assign ev_code     = head_r.code;
    assign ev_ext      = head_r.ext;
    assign ev_break    = head_r.brk;
    assign frame_err   = rx_err_s;
    assign ev_overflow = ev_overflow_r;

endmodule
